// File: rtl/ecdsa_sig_serializer.sv
// Captures a {r,s} signature on sig_done, range-checks r,s in [1,n-1] then streams WORD_W words MSB first.
// First word valid 2 cycles after capture; words hold stable under !out_ready, one word per cycle otherwise.
module ecdsa_sig_serializer #(
  parameter int unsigned  WORD_W  = 32,
  parameter logic [255:0] CURVE_N = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141,
  localparam int unsigned NUM_WORDS = 512 / WORD_W,
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              master_reset_n,
  input  logic [511:0]      sig_in,
  input  logic              sig_done,
  output logic              busy,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [IDX_W-1:0]  out_idx,
  output logic              sig_invalid,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_STREAM} state_t;

  state_t           r_state;
  logic [511:0]     r_shift;
  logic             r_chk_ph;
  logic             r_bad;
  logic             r_busy;
  logic             r_valid;
  logic             r_last;
  logic             r_invalid;
  logic             r_overrun;
  logic [IDX_W-1:0] r_idx;

  logic [255:0]     w_r;
  logic [255:0]     w_s;
  logic             w_bad;
  logic             w_fire;

  assign w_r    = r_shift[511:256];
  assign w_s    = r_shift[255:0];
  assign w_bad  = (w_r == '0) | (w_s == '0) | (w_r >= CURVE_N) | (w_s >= CURVE_N);
  assign w_fire = r_valid & out_ready;

  // The 256-bit magnitude compares are registered in the first CHECK cycle and acted on in the second.
  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_chk_ph  <= 1'b0;
      r_bad     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_invalid <= 1'b0;
      r_overrun <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_invalid <= 1'b0;

      if (sig_done && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (sig_done) begin
            r_shift  <= sig_in;
            r_state  <= S_CHECK;
            r_busy   <= 1'b1;
            r_chk_ph <= 1'b0;
          end
        end

        S_CHECK: begin
          if (!r_chk_ph) begin
            r_bad    <= w_bad;
            r_chk_ph <= 1'b1;
          end else begin
            r_chk_ph <= 1'b0;
            if (r_bad) begin
              r_invalid <= 1'b1;
              r_shift   <= '0;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_valid <= 1'b1;
              r_idx   <= '0;
              r_last  <= 1'b0;
              r_state <= S_STREAM;
            end
          end
        end

        S_STREAM: begin
          if (w_fire) begin
            r_shift <= r_shift << WORD_W;
            if (r_last) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_idx   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_idx  <= r_idx + IDX_ONE;
              r_last <= ((r_idx + IDX_ONE) == LAST_IDX);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign out_data    = r_shift[511 -: WORD_W];
  assign out_valid   = r_valid;
  assign out_last    = r_last;
  assign out_idx     = r_idx;
  assign sig_invalid = r_invalid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_ecdsa_sig_serializer.sv
// Scoreboard bench for ecdsa_sig_serializer at WORD_W = 32 (main), 8 and 64 (back-to-back streaming).
module tb_ecdsa_sig_serializer;

  localparam logic [255:0] N = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  idx;
    logic        last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] sig_in;
  logic         sd32, sd8, sd64, ready, clr;

  logic         b32, v32, l32, inv32, ov32;
  logic [31:0]  d32;
  logic [3:0]   i32;
  logic         b8, v8, l8, inv8, ov8;
  logic [7:0]   d8;
  logic [5:0]   i8;
  logic         b64, v64, l64, inv64, ov64;
  logic [63:0]  d64;
  logic [2:0]   i64;

  exp_t q32[$];
  exp_t q8[$];
  exp_t q64[$];

  int n_vec  = 0;
  int n_miss = 0;

  bit          prev_stall[3];
  logic [63:0] prev_d[3];
  logic [7:0]  prev_idx[3];
  bit          last_seen[3];

  always #5 clk = ~clk;

  ecdsa_sig_serializer #(.WORD_W(32)) u_dut32 (
    .clk(clk), .master_reset_n(rst_n), .sig_in(sig_in), .sig_done(sd32), .busy(b32),
    .out_data(d32), .out_valid(v32), .out_ready(ready), .out_last(l32), .out_idx(i32),
    .sig_invalid(inv32), .overrun(ov32), .clr_overrun(clr));

  ecdsa_sig_serializer #(.WORD_W(8)) u_dut8 (
    .clk(clk), .master_reset_n(rst_n), .sig_in(sig_in), .sig_done(sd8), .busy(b8),
    .out_data(d8), .out_valid(v8), .out_ready(ready), .out_last(l8), .out_idx(i8),
    .sig_invalid(inv8), .overrun(ov8), .clr_overrun(clr));

  ecdsa_sig_serializer #(.WORD_W(64)) u_dut64 (
    .clk(clk), .master_reset_n(rst_n), .sig_in(sig_in), .sig_done(sd64), .busy(b64),
    .out_data(d64), .out_valid(v64), .out_ready(ready), .out_last(l64), .out_idx(i64),
    .sig_invalid(inv64), .overrun(ov64), .clr_overrun(clr));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 0) ? 32 : ((i == 1) ? 8 : 64);
  endfunction

  function automatic logic [63:0] word_of(input logic [511:0] sig, input int k, input int w);
    logic [511:0] t;
    t = sig << (k * w);
    return t[511:448] >> (64 - w);
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q32.size() : ((i == 1) ? q8.size() : q64.size());
  endfunction

  task automatic get_out(input int i, output logic v, output logic b, output logic l,
                         output logic inv, output logic ov, output logic [63:0] d,
                         output logic [7:0] idx);
    case (i)
      0:       begin v = v32; b = b32; l = l32; inv = inv32; ov = ov32; d = 64'(d32); idx = 8'(i32); end
      1:       begin v = v8;  b = b8;  l = l8;  inv = inv8;  ov = ov8;  d = 64'(d8);  idx = 8'(i8);  end
      default: begin v = v64; b = b64; l = l64; inv = inv64; ov = ov64; d = d64;      idx = 8'(i64); end
    endcase
  endtask

  task automatic push_sig(input int i, input logic [511:0] sig);
    int   w;
    int   nw;
    exp_t e;
    w  = wid(i);
    nw = 512 / w;
    for (int k = 0; k < nw; k++) begin
      e.d    = word_of(sig, k, w);
      e.idx  = 8'(k);
      e.last = (k == nw - 1);
      case (i)
        0:       q32.push_back(e);
        1:       q8.push_back(e);
        default: q64.push_back(e);
      endcase
    end
  endtask

  task automatic pop(input int i, output exp_t e);
    case (i)
      0:       e = q32.pop_front();
      1:       e = q8.pop_front();
      default: e = q64.pop_front();
    endcase
  endtask

  task automatic mon(input int i);
    logic v, b, l, inv, ov;
    logic [63:0] d;
    logic [7:0] idx;
    exp_t e;
    int qs;
    get_out(i, v, b, l, inv, ov, d, idx);
    qs = qsize(i);
    if (last_seen[i]) begin
      check("busy_after_last", 64'(b), 64'd0);
      check("valid_after_last", 64'(v), 64'd0);
      last_seen[i] = 1'b0;
    end
    if (prev_stall[i]) begin
      check("stall_data", d, prev_d[i]);
      check("stall_idx", 64'(idx), 64'(prev_idx[i]));
      check("stall_valid", 64'(v), 64'd1);
    end
    prev_stall[i] = v && !ready;
    prev_d[i]     = d;
    prev_idx[i]   = idx;
    if (v) check("valid_without_expect", 64'(qs == 0), 64'd0);
    if (v && ready && qs > 0) begin
      pop(i, e);
      check("word_data", d, e.d);
      check("word_idx", 64'(idx), 64'(e.idx));
      check("word_last", 64'(l), 64'(e.last));
      if (e.last) last_seen[i] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) mon(i);
  end

  task automatic set_sd(input int i, input logic val);
    case (i)
      0:       sd32 = val;
      1:       sd8  = val;
      default: sd64 = val;
    endcase
  endtask

  task automatic send(input int i, input logic [511:0] sig, input bit good);
    sig_in = sig;
    set_sd(i, 1'b1);
    if (good) push_sig(i, sig);
    @(posedge clk); #1;
    set_sd(i, 1'b0);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_stream(input int i, input int mode, input int budget);
    logic v, b, l, inv, ov;
    logic [63:0] d;
    logic [7:0] idx;
    for (int c = 0; c < budget; c++) begin
      if (mode == 1)      ready = ((c % 4) == 0) || ((c % 4) == 3);
      else if (mode == 2) ready = 1'($urandom_range(0, 1));
      else                ready = 1'b1;
      @(posedge clk); #1;
      get_out(i, v, b, l, inv, ov, d, idx);
      if (!b && qsize(i) == 0) begin
        ready = 1'b1;
        return;
      end
    end
    get_out(i, v, b, l, inv, ov, d, idx);
    check("drain_busy", 64'(b), 64'd0);
    check("drain_queue", 64'(qsize(i)), 64'd0);
    ready = 1'b1;
  endtask

  task automatic wait_word(input int i, input int k, input bit want_last, input int budget);
    logic v, b, l, inv, ov;
    logic [63:0] d;
    logic [7:0] idx;
    for (int c = 0; c < budget; c++) begin
      get_out(i, v, b, l, inv, ov, d, idx);
      if (v && (want_last ? l : (idx == 8'(k)))) return;
      @(posedge clk); #1;
    end
    check("wait_word_valid", 64'(v), 64'd1);
  endtask

  logic [511:0] good_tab[4];
  int           mode_tab[4];
  logic [511:0] bad_tab[4];

  initial begin
    logic v, b, l, inv, ov;
    logic [63:0] d;
    logic [7:0] idx;

    good_tab[0] = {256'd1, 256'd2};                  mode_tab[0] = 0;
    good_tab[1] = {256'd1, 256'd2};                  mode_tab[1] = 1;
    good_tab[2] = {N - 256'd1, N - 256'd1};          mode_tab[2] = 0;
    good_tab[3] = {256'h0123456789ABCDEFFEDCBA98765432100F1E2D3C4B5A69788796A5B4C3D2E1F0,
                   256'h00000000000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF};
    mode_tab[3] = 2;
    bad_tab[0]  = {N, 256'd5};
    bad_tab[1]  = {256'd7, 256'd0};
    bad_tab[2]  = {256'd0, 256'd1};
    bad_tab[3]  = {256'd1, {256{1'b1}}};

    rst_n = 1'b0; sig_in = '0; sd32 = 1'b0; sd8 = 1'b0; sd64 = 1'b0; ready = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      get_out(i, v, b, l, inv, ov, d, idx);
      check("reset_busy", 64'(b), 64'd0);
      check("reset_valid", 64'(v), 64'd0);
      check("reset_last", 64'(l), 64'd0);
      check("reset_invalid", 64'(inv), 64'd0);
      check("reset_overrun", 64'(ov), 64'd0);
      check("reset_data", d, 64'd0);
      check("reset_idx", 64'(idx), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // valid signatures, first one also checks the two-cycle latency
    for (int t = 0; t < 4; t++) begin
      send(0, good_tab[t], 1'b1);
      if (t == 0) begin
        @(negedge clk);
        check("lat_busy_t0", 64'(b32), 64'd1);
        check("lat_valid_t0", 64'(v32), 64'd0);
        @(negedge clk);
        check("lat_valid_t1", 64'(v32), 64'd0);
        @(negedge clk);
        check("lat_valid_t2", 64'(v32), 64'd1);
        check("lat_idx_t2", 64'(i32), 64'd0);
      end
      run_stream(0, mode_tab[t], 400);
    end

    // out-of-range signatures
    for (int t = 0; t < 4; t++) begin
      send(0, bad_tab[t], 1'b0);
      @(negedge clk);
      check("inv_t0", 64'(inv32), 64'd0);
      check("inv_busy_t0", 64'(b32), 64'd1);
      @(negedge clk);
      check("inv_t1", 64'(inv32), 64'd0);
      @(negedge clk);
      check("inv_t2", 64'(inv32), 64'd1);
      check("inv_busy_t2", 64'(b32), 64'd0);
      check("inv_valid_t2", 64'(v32), 64'd0);
      @(negedge clk);
      check("inv_t3", 64'(inv32), 64'd0);
      check("inv_busy_t3", 64'(b32), 64'd0);
      @(posedge clk); #1;
    end

    // overrun: dropped sig_done at word 4 with a simultaneous clear, then clear alone
    send(0, good_tab[3], 1'b1);
    wait_word(0, 4, 1'b0, 50);
    sig_in = {256'd9, 256'd9};
    sd32 = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    sd32 = 1'b0; clr = 1'b0;
    check("overrun_set_wins", 64'(ov32), 64'd1);
    run_stream(0, 0, 100);
    check("overrun_held", 64'(ov32), 64'd1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("overrun_cleared", 64'(ov32), 64'd0);

    // async reset in the middle of a stream
    send(0, good_tab[2], 1'b1);
    wait_word(0, 9, 1'b0, 50);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(v32), 64'd0);
    check("arst_busy", 64'(b32), 64'd0);
    check("arst_data", 64'(d32), 64'd0);
    check("arst_idx", 64'(i32), 64'd0);
    check("arst_last", 64'(l32), 64'd0);
    q32.delete();
    for (int i = 0; i < 3; i++) begin
      prev_stall[i] = 1'b0;
      last_seen[i]  = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(0, good_tab[3], 1'b1);
    run_stream(0, 0, 100);

    // back-to-back: new sig_done in the IDLE cycle right after the last handshake
    for (int i = 0; i < 3; i++) begin
      ready = 1'b1;
      send(i, good_tab[3], 1'b1);
      wait_word(i, 0, 1'b1, 200);
      @(posedge clk); #1;
      send(i, good_tab[2], 1'b1);
      run_stream(i, 0, 300);
      get_out(i, v, b, l, inv, ov, d, idx);
      check("b2b_overrun", 64'(ov), 64'd0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", n_vec, n_miss);
    $fatal(1);
  end

endmodule
